// File: rtl/dma_copy.sv
// dma_copy: single-channel word-copy DMA engine. Configured through a one-cycle
// responder port; moves data as read/write beat pairs on the initiator port.
module dma_copy (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_ss_i,
    input  logic        bus_ttype_i,
    input  logic [7:0]  bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    output logic [31:0] bus_rdata_o,
    output logic        bus_bdone_o,
    output logic        mbus_ss_o,
    output logic        mbus_ttype_o,
    output logic [31:0] mbus_addr_o,
    output logic [31:0] mbus_wdata_o,
    input  logic [31:0] mbus_rdata_i,
    input  logic        mbus_bdone_i,
    output logic        irq_o
);
    localparam logic TT_READ  = 1'b0;
    localparam logic TT_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [15:0] len_q;
    logic        ien_q;
    logic        done_q;
    logic        aborted_q;
    logic        abort_pend_q;
    logic [31:0] cur_src_q;
    logic [31:0] cur_dst_q;
    logic [15:0] remain_q;
    logic        mbus_ss_q;
    logic        mbus_ttype_q;
    logic [31:0] mbus_addr_q;
    logic [31:0] mbus_wdata_q;

    logic [31:0] cur_src_d;
    logic [31:0] cur_dst_d;
    logic        cfg_wr;
    logic        busy;
    logic        start_req;
    logic        abort_req;
    logic        done_w1c;
    logic        aborted_w1c;

    // Configuration write decode and pulse generation.
    always_comb begin
        cfg_wr      = bus_ss_i && (bus_ttype_i == TT_WRITE);
        busy        = (state_q != S_IDLE);
        cur_src_d   = cur_src_q + 32'd4;
        cur_dst_d   = cur_dst_q + 32'd4;
        start_req   = 1'b0;
        abort_req   = 1'b0;
        done_w1c    = 1'b0;
        aborted_w1c = 1'b0;
        if (cfg_wr) begin
            case (bus_addr_i)
                8'h0C: begin
                    start_req = bus_wdata_i[0] && !busy;
                    abort_req = bus_wdata_i[2] && busy;
                end
                8'h10: begin
                    done_w1c    = bus_wdata_i[1];
                    aborted_w1c = bus_wdata_i[2];
                end
                default: begin
                    start_req = 1'b0;
                end
            endcase
        end else begin
            start_req = 1'b0;
        end
    end

    // Register read mux; START and ABORT always read back as zero.
    always_comb begin
        bus_rdata_o = 32'd0;
        case (bus_addr_i)
            8'h00:   bus_rdata_o = src_q;
            8'h04:   bus_rdata_o = dst_q;
            8'h08:   bus_rdata_o = {16'd0, len_q};
            8'h0C:   bus_rdata_o = {29'd0, 1'b0, ien_q, 1'b0};
            8'h10:   bus_rdata_o = {29'd0, aborted_q, done_q, busy};
            default: bus_rdata_o = 32'd0;
        endcase
    end

    assign bus_bdone_o  = 1'b1;
    assign mbus_ss_o    = mbus_ss_q;
    assign mbus_ttype_o = mbus_ttype_q;
    assign mbus_addr_o  = mbus_addr_q;
    assign mbus_wdata_o = mbus_wdata_q;
    assign irq_o        = done_q & ien_q;

    // Programmed registers; transfer parameters are frozen while a copy runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= 32'd0;
            dst_q <= 32'd0;
            len_q <= 16'd0;
            ien_q <= 1'b0;
        end else if (cfg_wr) begin
            case (bus_addr_i)
                8'h00: if (!busy) src_q <= {bus_wdata_i[31:2], 2'b00};
                8'h04: if (!busy) dst_q <= {bus_wdata_i[31:2], 2'b00};
                8'h08: if (!busy) len_q <= bus_wdata_i[15:0];
                8'h0C: ien_q <= bus_wdata_i[1];
                default: ;
            endcase
        end
    end

    // Copy FSM with registered initiator outputs and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            cur_src_q    <= 32'd0;
            cur_dst_q    <= 32'd0;
            remain_q     <= 16'd0;
            mbus_ss_q    <= 1'b0;
            mbus_ttype_q <= TT_READ;
            mbus_addr_q  <= 32'd0;
            mbus_wdata_q <= 32'd0;
        end else begin
            // Clears come first so a same-edge set from the FSM wins.
            if (done_w1c)    done_q       <= 1'b0;
            if (aborted_w1c) aborted_q    <= 1'b0;
            if (abort_req)   abort_pend_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    abort_pend_q <= 1'b0;
                    if (start_req) begin
                        if (len_q == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q      <= S_RD;
                            cur_src_q    <= src_q;
                            cur_dst_q    <= dst_q;
                            remain_q     <= len_q;
                            mbus_ss_q    <= 1'b1;
                            mbus_ttype_q <= TT_READ;
                            mbus_addr_q  <= src_q;
                        end
                    end
                end
                S_RD: begin
                    if (mbus_bdone_i) begin
                        // The write-data register doubles as the word buffer.
                        state_q      <= S_WR;
                        mbus_ttype_q <= TT_WRITE;
                        mbus_addr_q  <= cur_dst_q;
                        mbus_wdata_q <= mbus_rdata_i;
                    end
                end
                S_WR: begin
                    if (mbus_bdone_i) begin
                        remain_q  <= remain_q - 16'd1;
                        cur_src_q <= cur_src_d;
                        cur_dst_q <= cur_dst_d;
                        if (remain_q == 16'd1) begin
                            state_q      <= S_IDLE;
                            mbus_ss_q    <= 1'b0;
                            done_q       <= 1'b1;
                            abort_pend_q <= 1'b0;
                        end else if (abort_pend_q) begin
                            state_q      <= S_IDLE;
                            mbus_ss_q    <= 1'b0;
                            aborted_q    <= 1'b1;
                            abort_pend_q <= 1'b0;
                        end else begin
                            state_q      <= S_RD;
                            mbus_ttype_q <= TT_READ;
                            mbus_addr_q  <= cur_src_d;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mbus_ss_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: behavioural memory slave with programmable
// wait states, beat logger, request-stability monitor and immediate-assert checks.
module tb_dma_copy;
    logic        clk;
    logic        rst;
    logic        bus_ss;
    logic        bus_ttype;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_bdone;
    logic        mbus_ss;
    logic        mbus_ttype;
    logic [31:0] mbus_addr;
    logic [31:0] mbus_wdata;
    logic [31:0] mbus_rdata;
    logic        mbus_bdone;
    logic        irq;

    int          checks;
    int          failures;
    int          n_wait;
    int          stall_cnt;
    int          ss_cycles;
    int          stab_err;
    logic [7:0]  log_n;
    logic        log_tt   [0:255];
    logic [31:0] log_addr [0:255];
    logic [31:0] log_data [0:255];
    logic        hold_v;
    logic        hold_tt;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;

    dma_copy dut (
        .clk          (clk),
        .rst          (rst),
        .bus_ss_i     (bus_ss),
        .bus_ttype_i  (bus_ttype),
        .bus_addr_i   (bus_addr),
        .bus_wdata_i  (bus_wdata),
        .bus_rdata_o  (bus_rdata),
        .bus_bdone_o  (bus_bdone),
        .mbus_ss_o    (mbus_ss),
        .mbus_ttype_o (mbus_ttype),
        .mbus_addr_o  (mbus_addr),
        .mbus_wdata_o (mbus_wdata),
        .mbus_rdata_i (mbus_rdata),
        .mbus_bdone_i (mbus_bdone),
        .irq_o        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    assign mbus_rdata = pat(mbus_addr);
    assign mbus_bdone = mbus_ss && (stall_cnt >= n_wait);

    initial begin
        stall_cnt = 0; ss_cycles = 0; stab_err = 0; log_n = 8'd0; hold_v = 1'b0;
        hold_tt = 1'b0; hold_addr = 32'd0; hold_wdata = 32'd0;
    end

    // Slave wait-state counter, beat logger and request-hold monitor.
    always @(posedge clk) begin
        if (mbus_ss && !mbus_bdone) stall_cnt <= stall_cnt + 1;
        else                        stall_cnt <= 0;
        if (mbus_ss) ss_cycles <= ss_cycles + 1;
        if (mbus_ss && mbus_bdone) begin
            log_tt[log_n]   <= mbus_ttype;
            log_addr[log_n] <= mbus_addr;
            log_data[log_n] <= mbus_ttype ? mbus_wdata : mbus_rdata;
            log_n           <= log_n + 8'd1;
        end
        if (hold_v && (!mbus_ss || mbus_ttype !== hold_tt || mbus_addr !== hold_addr ||
                       mbus_wdata !== hold_wdata))
            stab_err <= stab_err + 1;
        hold_v     <= mbus_ss && !mbus_bdone && !rst;
        hold_tt    <= mbus_ttype;
        hold_addr  <= mbus_addr;
        hold_wdata <= mbus_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_ss = 1'b1; bus_ttype = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        bus_ss = 1'b0; bus_ttype = 1'b0;
    endtask

    task automatic cfg_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_ss = 1'b1; bus_ttype = 1'b0; bus_addr = a;
        #1 d = bus_rdata;
        @(posedge clk); #1;
        bus_ss = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        cfg_rd(a, v);
        chk(tag, v, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (mbus_ss === 1'b1 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, {31'd0, mbus_ss}, 32'd0);
    endtask

    task automatic wait_beat(input string tag, input logic tt, input logic [31:0] a);
        int n;
        n = 0;
        while (!(mbus_ss === 1'b1 && mbus_ttype === tt && mbus_addr === a) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, {31'd0, (mbus_ss === 1'b1 && mbus_ttype === tt && mbus_addr === a)}, 32'd1);
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] idx, input logic tt,
                            input logic [31:0] a, input logic [31:0] d);
        chk($sformatf("%s_tt", tag),   {31'd0, log_tt[idx]}, {31'd0, tt});
        chk($sformatf("%s_addr", tag), log_addr[idx], a);
        chk($sformatf("%s_data", tag), log_data[idx], d);
    endtask

    logic [7:0]  b0;
    int          s0;
    int          e0;
    logic [31:0] rv;

    initial begin
        checks = 0; failures = 0; n_wait = 0;
        rst = 1'b1; bus_ss = 1'b0; bus_ttype = 1'b0; bus_addr = 8'd0; bus_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss",    {31'd0, mbus_ss},    32'd0);
        chk("rst_ttype", {31'd0, mbus_ttype}, 32'd0);
        chk("rst_addr",  mbus_addr,           32'd0);
        chk("rst_wdata", mbus_wdata,          32'd0);
        chk("rst_irq",   {31'd0, irq},        32'd0);
        rst = 1'b0;
        chk_reg("rst_src",    8'h00, 32'd0);
        chk_reg("rst_status", 8'h10, 32'd0);

        // Basic copy, zero-wait.
        cfg_wr(8'h00, 32'h0000_1000);
        cfg_wr(8'h04, 32'h0000_2000);
        cfg_wr(8'h08, 32'd3);
        b0 = log_n; s0 = ss_cycles;
        cfg_wr(8'h0C, 32'h3);
        chk("t1_first_ss",   {31'd0, mbus_ss},    32'd1);
        chk("t1_first_addr", mbus_addr,           32'h0000_1000);
        chk("t1_first_tt",   {31'd0, mbus_ttype}, 32'd0);
        wait_idle("t1_timeout");
        chk("t1_irq", {31'd0, irq}, 32'd1);
        chk("t1_ss_cycles", ss_cycles - s0, 32'd6);
        chk("t1_beats", {24'd0, log_n - b0}, 32'd6);
        chk_beat("t1_b0", b0 + 8'd0, 1'b0, 32'h1000, pat(32'h1000));
        chk_beat("t1_b1", b0 + 8'd1, 1'b1, 32'h2000, pat(32'h1000));
        chk_beat("t1_b2", b0 + 8'd2, 1'b0, 32'h1004, pat(32'h1004));
        chk_beat("t1_b3", b0 + 8'd3, 1'b1, 32'h2004, pat(32'h1004));
        chk_beat("t1_b4", b0 + 8'd4, 1'b0, 32'h1008, pat(32'h1008));
        chk_beat("t1_b5", b0 + 8'd5, 1'b1, 32'h2008, pat(32'h1008));
        chk_reg("t1_status", 8'h10, 32'h2);
        cfg_wr(8'h10, 32'h2);
        chk("t1_irq_clr", {31'd0, irq}, 32'd0);
        chk_reg("t1_status_clr", 8'h10, 32'h0);

        // Wait states: three stall cycles per beat.
        n_wait = 3;
        cfg_wr(8'h00, 32'h0000_3000);
        cfg_wr(8'h04, 32'h0000_4000);
        cfg_wr(8'h08, 32'd2);
        b0 = log_n; s0 = ss_cycles; e0 = stab_err;
        cfg_wr(8'h0C, 32'h1);
        wait_idle("t2_timeout");
        chk("t2_ss_cycles", ss_cycles - s0, 32'd16);
        chk("t2_beats", {24'd0, log_n - b0}, 32'd4);
        chk("t2_stable", stab_err - e0, 32'd0);
        chk_beat("t2_b1", b0 + 8'd1, 1'b1, 32'h4000, pat(32'h3000));
        chk_beat("t2_b3", b0 + 8'd3, 1'b1, 32'h4004, pat(32'h3004));
        n_wait = 0;
        cfg_wr(8'h10, 32'h2);

        // LEN=0 start, then busy protection.
        cfg_wr(8'h08, 32'd0);
        s0 = ss_cycles;
        cfg_wr(8'h0C, 32'h1);
        chk("t3_len0_ss", {31'd0, mbus_ss}, 32'd0);
        chk_reg("t3_len0_status", 8'h10, 32'h2);
        chk("t3_len0_no_ss", ss_cycles - s0, 32'd0);
        cfg_wr(8'h10, 32'h2);
        cfg_wr(8'h00, 32'h0000_5000);
        cfg_wr(8'h04, 32'h0000_6000);
        cfg_wr(8'h08, 32'd4);
        b0 = log_n;
        cfg_wr(8'h0C, 32'h1);
        cfg_wr(8'h00, 32'hDEAD_0000);
        cfg_wr(8'h0C, 32'h1);
        chk_reg("t3_busy_status", 8'h10, 32'h1);
        chk_reg("t3_src_kept",    8'h00, 32'h0000_5000);
        wait_idle("t3_timeout");
        chk("t3_beats", {24'd0, log_n - b0}, 32'd8);
        chk_beat("t3_b6", b0 + 8'd6, 1'b0, 32'h500C, pat(32'h500C));
        chk_beat("t3_b7", b0 + 8'd7, 1'b1, 32'h600C, pat(32'h500C));
        chk_reg("t3_src_after", 8'h00, 32'h0000_5000);
        cfg_wr(8'h10, 32'h2);

        // Abort during the second read.
        n_wait = 2;
        cfg_wr(8'h00, 32'h0000_7000);
        cfg_wr(8'h04, 32'h0000_8000);
        cfg_wr(8'h08, 32'd10);
        b0 = log_n;
        cfg_wr(8'h0C, 32'h1);
        wait_beat("t4_reach_rd2", 1'b0, 32'h0000_7004);
        cfg_wr(8'h0C, 32'h4);
        wait_idle("t4_timeout");
        chk("t4_beats", {24'd0, log_n - b0}, 32'd4);
        chk_beat("t4_b3", b0 + 8'd3, 1'b1, 32'h8004, pat(32'h7004));
        chk_reg("t4_status", 8'h10, 32'h4);
        chk_reg("t4_ctrl",   8'h0C, 32'h0);
        cfg_wr(8'h10, 32'h4);
        cfg_wr(8'h0C, 32'h4);
        chk_reg("t4_idle_abort", 8'h10, 32'h0);
        n_wait = 0;

        // Address wrap and alignment.
        cfg_wr(8'h00, 32'hFFFF_FFFE);
        chk_reg("t5_src_align", 8'h00, 32'hFFFF_FFFC);
        cfg_wr(8'h04, 32'h0000_9000);
        cfg_wr(8'h08, 32'd2);
        b0 = log_n;
        cfg_wr(8'h0C, 32'h1);
        wait_idle("t5_timeout");
        chk("t5_beats", {24'd0, log_n - b0}, 32'd4);
        chk_beat("t5_b0", b0 + 8'd0, 1'b0, 32'hFFFF_FFFC, pat(32'hFFFF_FFFC));
        chk_beat("t5_b2", b0 + 8'd2, 1'b0, 32'h0000_0000, pat(32'h0000_0000));
        chk_beat("t5_b3", b0 + 8'd3, 1'b1, 32'h0000_9004, pat(32'h0000_0000));
        cfg_wr(8'h10, 32'h2);

        // Reset during the second write.
        cfg_wr(8'h00, 32'h0000_A000);
        cfg_wr(8'h04, 32'h0000_B000);
        cfg_wr(8'h08, 32'd5);
        cfg_wr(8'h0C, 32'h3);
        wait_beat("t6_reach_wr2", 1'b1, 32'h0000_B004);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_ss", {31'd0, mbus_ss}, 32'd0);
        chk("t6_irq", {31'd0, irq}, 32'd0);
        chk_reg("t6_src",    8'h00, 32'd0);
        chk_reg("t6_dst",    8'h04, 32'd0);
        chk_reg("t6_len",    8'h08, 32'd0);
        chk_reg("t6_ctrl",   8'h0C, 32'd0);
        chk_reg("t6_status", 8'h10, 32'd0);
        cfg_wr(8'h00, 32'h0000_C000);
        cfg_wr(8'h04, 32'h0000_D000);
        cfg_wr(8'h08, 32'd1);
        b0 = log_n;
        cfg_wr(8'h0C, 32'h1);
        wait_idle("t6_timeout");
        chk("t6_beats", {24'd0, log_n - b0}, 32'd2);
        chk_beat("t6_b1", b0 + 8'd1, 1'b1, 32'hD000, pat(32'hC000));
        chk_reg("t6_done", 8'h10, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
